// File: rtl/ntt_stage_sched_if.sv
// ntt_stage_sched_if: bundle between the NTT scheduler and its RAM, twiddle ROM and butterfly pipeline.
interface ntt_stage_sched_if #(
    parameter int DW   = 12,
    parameter int LOGN = 8
);
    logic            start, busy, done, err;
    logic [LOGN-1:0] rd_addr_a, rd_addr_b, tw_addr;
    logic [DW-1:0]   rd_data_a, rd_data_b, tw_data;
    logic            bf_en, bf_valid, wr_en;
    logic [DW-1:0]   bf_x, bf_y, bf_w, bf_xout, bf_yout;
    logic [LOGN-1:0] wr_addr_a, wr_addr_b;
    logic [DW-1:0]   wr_data_a, wr_data_b;

    modport master (
        input  start, rd_data_a, rd_data_b, tw_data, bf_valid, bf_xout, bf_yout,
        output busy, done, err, rd_addr_a, rd_addr_b, tw_addr, bf_en, bf_x, bf_y, bf_w,
               wr_en, wr_addr_a, wr_addr_b, wr_data_a, wr_data_b
    );
    modport slave (
        output start, rd_data_a, rd_data_b, tw_data, bf_valid, bf_xout, bf_yout,
        input  busy, done, err, rd_addr_a, rd_addr_b, tw_addr, bf_en, bf_x, bf_y, bf_w,
               wr_en, wr_addr_a, wr_addr_b, wr_data_a, wr_data_b
    );
endinterface

// File: rtl/ntt_stage_sched.sv
// ntt_stage_sched: in-place radix-2 Cooley-Tukey NTT scheduler feeding an external butterfly pipeline.
// Write-back addresses ride a FIFO alongside the pipeline; each stage drains fully before the next.
module ntt_stage_sched #(
    parameter int DW     = 12,
    parameter int LOGN   = 8,
    parameter int BF_LAT = 5,
    parameter int AQ_DEP = 8
) (
    input  logic              clk,
    input  logic              reset,
    ntt_stage_sched_if.master bus
);
    localparam int N  = 1 << LOGN;
    localparam int SW = $clog2(LOGN + 1);
    localparam int QW = (AQ_DEP > 1) ? $clog2(AQ_DEP) : 1;
    localparam int CW = $clog2(AQ_DEP + 1);

    typedef enum logic [1:0] {IDLE, ISSUE, DRAIN, FIN} state_t;

    if (AQ_DEP < BF_LAT + 2 || DW < 1) begin : g_param_chk
        $error("AQ_DEP must cover BF_LAT+2 in-flight butterflies");
    end

    state_t          state_q, state_d;
    logic [SW-1:0]   s_q, s_d;
    logic [LOGN-1:0] g_q, g_d, k_q, k_d;
    logic [LOGN-1:0] rd_addr_a_q, rd_addr_a_d, rd_addr_b_q, rd_addr_b_d, tw_addr_q, tw_addr_d;
    logic            rd_pend_q, rd_pend_d, bf_en_q, bf_en_d;
    logic            busy_q, busy_d, done_q, done_d, err_q, err_d;
    logic [QW-1:0]   wp_q, wp_d, rp_q, rp_d;
    logic [CW-1:0]   cnt_q, cnt_d;
    logic [LOGN-1:0] aq_a_q [AQ_DEP];
    logic [LOGN-1:0] aq_a_d [AQ_DEP];
    logic [LOGN-1:0] aq_b_q [AQ_DEP];
    logic [LOGN-1:0] aq_b_d [AQ_DEP];
    logic [LOGN-1:0] len, idx;
    logic            push, pop, full, empty, last_k, last_g, last_s;

    always_comb begin
        len         = LOGN'(N >> (s_q + 1'b1));
        idx         = (g_q << (LOGN - 32'(s_q))) + k_q;
        last_k      = k_q == len - 1'b1;
        last_g      = g_q == (LOGN'(1) << s_q) - 1'b1;
        last_s      = s_q == SW'(LOGN - 1);
        full        = cnt_q == CW'(AQ_DEP);
        empty       = cnt_q == '0;
        push        = rd_pend_q && !full;
        pop         = bus.bf_valid && !empty;
        wp_d        = push ? ((wp_q == QW'(AQ_DEP - 1)) ? '0 : wp_q + 1'b1) : wp_q;
        rp_d        = pop ? ((rp_q == QW'(AQ_DEP - 1)) ? '0 : rp_q + 1'b1) : rp_q;
        cnt_d       = cnt_q + CW'(push) - CW'(pop);
        aq_a_d      = aq_a_q;
        aq_b_d      = aq_b_q;
        if (push) begin
            aq_a_d[wp_q] = rd_addr_a_q;
            aq_b_d[wp_q] = rd_addr_b_q;
        end
        err_d       = err_q || (rd_pend_q && full) || (bus.bf_valid && empty);
        bf_en_d     = rd_pend_q;
        state_d     = state_q;
        s_d         = s_q;
        g_d         = g_q;
        k_d         = k_q;
        rd_addr_a_d = rd_addr_a_q;
        rd_addr_b_d = rd_addr_b_q;
        tw_addr_d   = tw_addr_q;
        rd_pend_d   = 1'b0;
        busy_d      = busy_q;
        done_d      = 1'b0;
        case (state_q)
            IDLE: if (bus.start) begin
                state_d = ISSUE;
                busy_d  = 1'b1;
                s_d     = '0;
                g_d     = '0;
                k_d     = '0;
            end
            ISSUE: begin
                rd_addr_a_d = idx;
                rd_addr_b_d = idx + len;
                tw_addr_d   = (LOGN'(1) << s_q) + g_q;
                rd_pend_d   = 1'b1;
                k_d         = last_k ? '0 : k_q + 1'b1;
                g_d         = last_k ? (last_g ? '0 : g_q + 1'b1) : g_q;
                state_d     = (last_k && last_g) ? DRAIN : ISSUE;
            end
            // leave on the cycle of the final write-back so the next stage reads fresh data
            DRAIN: if (!rd_pend_q && cnt_d == '0) begin
                state_d = last_s ? FIN : ISSUE;
                s_d     = last_s ? s_q : s_q + 1'b1;
            end
            FIN: begin
                state_d = IDLE;
                busy_d  = 1'b0;
                done_d  = 1'b1;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= IDLE;
            s_q         <= '0;
            g_q         <= '0;
            k_q         <= '0;
            rd_addr_a_q <= '0;
            rd_addr_b_q <= '0;
            tw_addr_q   <= '0;
            rd_pend_q   <= 1'b0;
            bf_en_q     <= 1'b0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            err_q       <= 1'b0;
            wp_q        <= '0;
            rp_q        <= '0;
            cnt_q       <= '0;
            aq_a_q      <= '{default: '0};
            aq_b_q      <= '{default: '0};
        end else begin
            state_q     <= state_d;
            s_q         <= s_d;
            g_q         <= g_d;
            k_q         <= k_d;
            rd_addr_a_q <= rd_addr_a_d;
            rd_addr_b_q <= rd_addr_b_d;
            tw_addr_q   <= tw_addr_d;
            rd_pend_q   <= rd_pend_d;
            bf_en_q     <= bf_en_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
            err_q       <= err_d;
            wp_q        <= wp_d;
            rp_q        <= rp_d;
            cnt_q       <= cnt_d;
            aq_a_q      <= aq_a_d;
            aq_b_q      <= aq_b_d;
        end
    end

    assign bus.busy      = busy_q;
    assign bus.done      = done_q;
    assign bus.err       = err_q;
    assign bus.rd_addr_a = rd_addr_a_q;
    assign bus.rd_addr_b = rd_addr_b_q;
    assign bus.tw_addr   = tw_addr_q;
    assign bus.bf_en     = bf_en_q;
    assign bus.bf_x      = bus.rd_data_a;
    assign bus.bf_y      = bus.rd_data_b;
    assign bus.bf_w      = bus.tw_data;
    assign bus.wr_en     = pop;
    assign bus.wr_addr_a = aq_a_q[rp_q];
    assign bus.wr_addr_b = aq_b_q[rp_q];
    assign bus.wr_data_a = bus.bf_xout;
    assign bus.wr_data_b = bus.bf_yout;
endmodule

// File: tb/tb_ntt_stage_sched.sv
// tb_ntt_stage_sched: behavioural RAM, twiddle ROM and mod-q butterfly pipeline around the scheduler;
// results are compared with a software NTT and the issue order with the stage/group/k enumeration.
module tb_ntt_stage_sched;
    localparam int DW = 12, LOGN = 3, BF_LAT = 5, AQ_DEP = 8;
    localparam int N = 1 << LOGN, H = N / 2, Q = 3329;
    localparam int LAT = LOGN * (H + BF_LAT + 2) + 2;

    logic clk = 1'b0, reset = 1'b1, force_v = 1'b0, load = 1'b0, mon_clr = 1'b1;
    int checks = 0, failures = 0;
    int ram [N];
    int init_v [N];
    int rom [N];
    int gold [N];
    logic pipe_v [BF_LAT];
    int pipe_x [BF_LAT];
    int pipe_y [BF_LAT];
    logic [LOGN-1:0] pa, pb, pt;
    int w0, w1, nbf, ord_viol, ndone;
    int log_a [$];
    int log_b [$];
    int log_t [$];

    always #5 clk = ~clk;

    ntt_stage_sched_if #(.DW(DW), .LOGN(LOGN)) bus ();
    ntt_stage_sched #(.DW(DW), .LOGN(LOGN), .BF_LAT(BF_LAT), .AQ_DEP(AQ_DEP)) dut (
        .clk(clk), .reset(reset), .bus(bus));

    function automatic int bf_out(input logic [DW-1:0] x, y, w, input logic upper);
        int t;
        t = (int'(w) * int'(y)) % Q;
        return upper ? (int'(x) + t) % Q : (int'(x) - t + Q) % Q;
    endfunction

    always @(posedge clk) begin
        if (load) ram <= init_v;
        else if (bus.wr_en) begin
            ram[bus.wr_addr_a] <= int'(bus.wr_data_a);
            ram[bus.wr_addr_b] <= int'(bus.wr_data_b);
        end
        bus.rd_data_a <= DW'(ram[bus.rd_addr_a]);
        bus.rd_data_b <= DW'(ram[bus.rd_addr_b]);
        bus.tw_data   <= DW'(rom[bus.tw_addr]);
    end

    always @(posedge clk) begin
        for (int j = BF_LAT - 1; j > 0; j--) begin
            pipe_v[j] <= pipe_v[j-1] && !reset;
            pipe_x[j] <= pipe_x[j-1];
            pipe_y[j] <= pipe_y[j-1];
        end
        pipe_v[0] <= bus.bf_en && !reset;
        pipe_x[0] <= bf_out(bus.bf_x, bus.bf_y, bus.bf_w, 1'b1);
        pipe_y[0] <= bf_out(bus.bf_x, bus.bf_y, bus.bf_w, 1'b0);
    end

    assign bus.bf_valid = pipe_v[BF_LAT-1] || force_v;
    assign bus.bf_xout  = DW'(pipe_x[BF_LAT-1]);
    assign bus.bf_yout  = DW'(pipe_y[BF_LAT-1]);

    // w0 = writes completed strictly before the address cycle of the current bf_en
    always @(negedge clk) begin
        if (mon_clr) begin
            w0 <= 0; w1 <= 0; nbf <= 0; ord_viol <= 0; ndone <= 0;
            log_a.delete(); log_b.delete(); log_t.delete();
        end else begin
            if (bus.bf_en) begin
                log_a.push_back(int'(pa));
                log_b.push_back(int'(pb));
                log_t.push_back(int'(pt));
                if (w0 < (nbf / H) * H) ord_viol <= ord_viol + 1;
                nbf <= nbf + 1;
            end
            if (bus.done) ndone <= ndone + 1;
            w0 <= w1;
            w1 <= w1 + int'(bus.wr_en);
        end
        pa <= bus.rd_addr_a;
        pb <= bus.rd_addr_b;
        pt <= bus.tw_addr;
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic mon_clear();
        mon_clr = 1'b1;
        @(negedge clk);
        #1 mon_clr = 1'b0;
    endtask

    task automatic load_ram(input bit ramp);
        for (int i = 0; i < N; i++) init_v[i] = ramp ? i : int'($urandom_range(Q - 1));
        for (int i = 0; i < N; i++) rom[i] = int'($urandom_range(Q - 1));
        gold = init_v;
        load = 1'b1;
        tick();
        load = 1'b0;
    endtask

    task automatic ntt_gold();
        int len, i, t, u;
        for (int s = 0; s < LOGN; s++) begin
            len = N >> (s + 1);
            for (int g = 0; g < (1 << s); g++)
                for (int k = 0; k < len; k++) begin
                    i = g * 2 * len + k;
                    t = (rom[(1 << s) + g] * gold[i + len]) % Q;
                    u = gold[i];
                    gold[i] = (u + t) % Q;
                    gold[i + len] = (u - t + Q) % Q;
                end
        end
    endtask

    function automatic int ram_diff();
        int d = 0;
        for (int i = 0; i < N; i++) if (ram[i] != gold[i]) d++;
        return d;
    endfunction

    task automatic run(output int lat);
        mon_clear();
        bus.start = 1'b1;
        lat = 0;
        do begin
            tick();
            bus.start = 1'b0;
            lat++;
        end while (!bus.done && lat < 4 * LAT);
    endtask

    task automatic test_reset();
        reset = 1'b1;
        repeat (3) tick();
        checks++;
        if ({bus.busy, bus.done, bus.err, bus.bf_en, bus.wr_en} !== 5'b0) begin
            failures++;
            $display("FAIL reset_flags: busy/done/err/bf_en/wr_en=%b want 00000",
                     {bus.busy, bus.done, bus.err, bus.bf_en, bus.wr_en});
        end
        checks++;
        if ({bus.rd_addr_a, bus.rd_addr_b, bus.tw_addr} !== '0) begin
            failures++;
            $display("FAIL reset_addr: rd_a=%0d rd_b=%0d tw=%0d want 0 0 0", bus.rd_addr_a, bus.rd_addr_b, bus.tw_addr);
        end
        reset = 1'b0;
        tick();
    endtask

    task automatic test_schedule();
        int lat, e, len;
        load_ram(1'b1);
        ntt_gold();
        run(lat);
        checks++;
        if (lat !== LAT) begin failures++; $display("FAIL sched_latency: got %0d want %0d", lat, LAT); end
        repeat (4) tick();
        checks++;
        if (ndone !== 1) begin failures++; $display("FAIL sched_done_count: got %0d want 1", ndone); end
        checks++;
        if (log_a.size() !== LOGN * H) begin
            failures++; $display("FAIL sched_issue_count: got %0d want %0d", log_a.size(), LOGN * H);
        end
        e = 0;
        for (int s = 0; s < LOGN; s++) begin
            len = N >> (s + 1);
            for (int g = 0; g < (1 << s); g++)
                for (int k = 0; k < len; k++) begin
                    if (e < log_a.size()) begin
                        checks++;
                        if (log_a[e] !== g * 2 * len + k || log_b[e] !== g * 2 * len + k + len || log_t[e] !== (1 << s) + g) begin
                            failures++;
                            $display("FAIL sched_pair[%0d]: got (%0d,%0d) tw %0d want (%0d,%0d) tw %0d", e,
                                     log_a[e], log_b[e], log_t[e], g * 2 * len + k, g * 2 * len + k + len, (1 << s) + g);
                        end
                    end
                    e++;
                end
        end
        checks++;
        if (ord_viol !== 0) begin failures++; $display("FAIL sched_raw_order: violations %0d want 0", ord_viol); end
        checks++;
        if (ram_diff() !== 0) begin failures++; $display("FAIL sched_result: %0d words differ want 0", ram_diff()); end
        checks++;
        if ({bus.busy, bus.err} !== 2'b00) begin
            failures++; $display("FAIL sched_idle: busy/err=%b want 00", {bus.busy, bus.err});
        end
    endtask

    task automatic test_random();
        int lat;
        for (int r = 0; r < 3; r++) begin
            load_ram(1'b0);
            ntt_gold();
            repeat ($urandom_range(3)) tick();
            run(lat);
            checks++;
            if (lat !== LAT) begin failures++; $display("FAIL rand_latency[%0d]: got %0d want %0d", r, lat, LAT); end
            checks++;
            if (ram_diff() !== 0) begin failures++; $display("FAIL rand_result[%0d]: %0d words differ want 0", r, ram_diff()); end
            checks++;
            if (ord_viol !== 0) begin failures++; $display("FAIL rand_raw_order[%0d]: violations %0d want 0", r, ord_viol); end
        end
    endtask

    task automatic test_start_busy();
        int lat;
        load_ram(1'b0);
        ntt_gold();
        mon_clear();
        bus.start = 1'b1;
        lat = 0;
        do begin
            tick();
            lat++;
            bus.start = (lat == 10 || lat == LAT - 2 || lat == LAT - 1);
        end while (!bus.done && lat < 4 * LAT);
        bus.start = 1'b0;
        checks++;
        if (lat !== LAT) begin failures++; $display("FAIL busy_start_latency: got %0d want %0d", lat, LAT); end
        repeat (6) tick();
        checks++;
        if (bus.busy !== 1'b0) begin failures++; $display("FAIL busy_start_restart: busy=%b want 0", bus.busy); end
        checks++;
        if (ndone !== 1) begin failures++; $display("FAIL busy_start_done_count: got %0d want 1", ndone); end
        checks++;
        if (ram_diff() !== 0) begin failures++; $display("FAIL busy_start_result: %0d words differ want 0", ram_diff()); end
    endtask

    task automatic test_err();
        tick();
        force_v = 1'b1;
        #1;
        checks++;
        if (bus.wr_en !== 1'b0) begin failures++; $display("FAIL err_wr_en: got %b want 0", bus.wr_en); end
        tick();
        force_v = 1'b0;
        checks++;
        if (bus.err !== 1'b1) begin failures++; $display("FAIL err_set: got %b want 1", bus.err); end
        repeat (5) tick();
        checks++;
        if ({bus.err, bus.busy} !== 2'b10) begin
            failures++; $display("FAIL err_sticky: err/busy=%b want 10", {bus.err, bus.busy});
        end
        reset = 1'b1;
        tick();
        reset = 1'b0;
        tick();
        checks++;
        if (bus.err !== 1'b0) begin failures++; $display("FAIL err_clear: got %b want 0", bus.err); end
    endtask

    task automatic test_reset_mid();
        int n, lat;
        load_ram(1'b0);
        mon_clear();
        bus.start = 1'b1;
        n = 0;
        do begin
            tick();
            bus.start = 1'b0;
            n++;
        end while (nbf <= H + 1 && n < 4 * LAT);
        checks++;
        if (nbf <= H + 1) begin failures++; $display("FAIL reset_mid_reach: issued %0d want >%0d", nbf, H + 1); end
        reset = 1'b1;
        tick();
        checks++;
        if ({bus.busy, bus.bf_en, bus.wr_en} !== 3'b000) begin
            failures++; $display("FAIL reset_mid_abort: busy/bf_en/wr_en=%b want 000", {bus.busy, bus.bf_en, bus.wr_en});
        end
        reset = 1'b0;
        load_ram(1'b0);
        ntt_gold();
        run(lat);
        checks++;
        if (lat !== LAT) begin failures++; $display("FAIL reset_mid_latency: got %0d want %0d", lat, LAT); end
        checks++;
        if (ram_diff() !== 0) begin failures++; $display("FAIL reset_mid_result: %0d words differ want 0", ram_diff()); end
        checks++;
        if (bus.err !== 1'b0) begin failures++; $display("FAIL reset_mid_err: got %b want 0", bus.err); end
    endtask

    task automatic test_back_to_back();
        int lat1, lat2;
        load_ram(1'b0);
        ntt_gold();
        run(lat1);
        ntt_gold();
        run(lat2);
        checks++;
        if ({lat1, lat2} !== {LAT, LAT}) begin
            failures++; $display("FAIL b2b_latency: got %0d,%0d want %0d,%0d", lat1, lat2, LAT, LAT);
        end
        repeat (4) tick();
        checks++;
        if (ndone !== 1) begin failures++; $display("FAIL b2b_done_count: got %0d want 1", ndone); end
        checks++;
        if (ram_diff() !== 0) begin failures++; $display("FAIL b2b_result: %0d words differ want 0", ram_diff()); end
    endtask

    initial begin
        bus.start = 1'b0;
        test_reset();
        test_schedule();
        test_random();
        test_start_busy();
        test_err();
        test_reset_mid();
        test_back_to_back();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
